// File: rtl/div4_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div4_seq
// Sequential unsigned restoring divider for the alu4 datapath. It produces one
// quotient bit per clock by shift-and-subtract. Operands arrive on a
// valid/ready request channel, and results leave on a valid/ready response
// channel. Every output is registered.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     request valid
//   in_ready     request accepted when in_valid && in_ready at a clk edge
//   dividend     numerator, sampled at the request handshake
//   divisor      denominator, sampled at the request handshake
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   quotient     result quotient (all ones on divide by zero)
//   remainder    result remainder (dividend on divide by zero)
//   zero         quotient == 0
//   div_by_zero  divisor was 0
// -----------------------------------------------------------------------------
module div4_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             div_by_zero
);

    // The step counter must be able to hold WIDTH.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic             r_divZero;
    logic             r_inReady;
    logic             r_outValid;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_zero;
    logic             r_dbz;

    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_qNext;

    // One restoring step. The partial remainder always stays below the
    // divisor, so it fits in WIDTH bits. Only the shifted value needs the
    // extra bit, and the borrow out of the trial subtraction appears in the
    // MSB of w_diff.
    always_comb begin
        w_remShift = {r_rem, r_q[WIDTH-1]};
        w_diff     = w_remShift - {1'b0, r_divisor};
        w_remNext  = w_diff[WIDTH] ? w_remShift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_qNext    = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
    end

    // Control FSM and datapath registers.
    // A divide-by-zero request also passes through CALC for a single cycle.
    // Its result is committed one edge after acceptance, so the response
    // timing stays fully registered for both paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            r_divZero   <= 1'b0;
            r_inReady   <= 1'b1;
            r_outValid  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_zero      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_inReady) begin
                        r_inReady <= 1'b0;
                        r_divisor <= divisor;
                        r_q       <= dividend;
                        r_rem     <= '0;
                        r_count   <= '0;
                        r_divZero <= (divisor == '0);
                        r_state   <= CALC;
                    end
                end

                CALC: begin
                    if (r_divZero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_q;
                        r_zero      <= 1'b0;
                        r_dbz       <= 1'b1;
                        r_outValid  <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_rem   <= w_remNext;
                        r_q     <= w_qNext;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST_STEP) begin
                            r_quotient  <= w_qNext;
                            r_remainder <= w_remNext;
                            r_zero      <= (w_qNext == '0);
                            r_dbz       <= 1'b0;
                            r_outValid  <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end

                default: begin
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_inReady;
    assign out_valid   = r_outValid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div4_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_div4_seq
// Self-checking bench for div4_seq (WIDTH = 4). Expected results come from
// plain integer division (/ and %) together with the divide-by-zero
// convention. Directed cases are followed by a sweep over all operand pairs
// with randomized out_ready.
// -----------------------------------------------------------------------------
module tb_div4_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         zero;
    logic         div_by_zero;

    int nChecks = 0;
    int nPass = 0;

    div4_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .zero       (zero),
        .div_by_zero(div_by_zero)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Keep the run from hanging if the design stops responding.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: ordinary integer division, plus the divide-by-zero rule.
    function automatic void refDiv(input int a, input int b,
                                   output int q, output int r,
                                   output int z, output int dbz);
        if (b == 0) begin
            q   = (1 << W) - 1;
            r   = a;
            z   = 0;
            dbz = 1;
        end else begin
            q   = a / b;
            r   = a % b;
            z   = (q == 0) ? 1 : 0;
            dbz = 0;
        end
    endfunction

    // One comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) begin
            nPass++;
        end else begin
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present one request at a negedge, hold it through one edge, then drop it.
    task automatic applyStimulus(input int a, input int b, input string tag);
        checkOutput({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges from the handshake until out_valid appears, then compare
    // that count with the required latency. With randomReady set, out_ready
    // is toggled while waiting because it must not matter before DONE.
    task automatic waitResult(input int expLat, input string tag, input bit randomReady);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (randomReady) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    endtask

    task automatic checkResult(input int a, input int b, input string tag);
        int q, r, z, dbz;
        refDiv(a, b, q, r, z, dbz);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_quotient"}, 32'(quotient), 32'(q));
        checkOutput({tag, "_remainder"}, 32'(remainder), 32'(r));
        checkOutput({tag, "_zero"}, 32'(zero), 32'(z));
        checkOutput({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(dbz));
    endtask

    // Consume the result for one edge and confirm the return to idle.
    task automatic acceptResult(input int a, input int b, input string tag);
        int q, r, z, dbz;
        refDiv(a, b, q, r, z, dbz);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_quotient_kept"}, 32'(quotient), 32'(q));
    endtask

    initial begin
        $display("[TB] div4_seq bench start");

        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_quotient", 32'(quotient), 32'd0);
        checkOutput("rst_remainder", 32'(remainder), 32'd0);
        checkOutput("rst_zero", 32'(zero), 32'd0);
        checkOutput("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // 13/3: normal latency of WIDTH cycles
        applyStimulus(13, 3, "d13_3");
        waitResult(W, "d13_3", 1'b0);
        checkResult(13, 3, "d13_3");
        acceptResult(13, 3, "d13_3");

        // 15/1, then 2/9. The second request waits until the first result
        // has been accepted.
        applyStimulus(15, 1, "d15_1");
        waitResult(W, "d15_1", 1'b0);
        checkResult(15, 1, "d15_1");
        in_valid = 1'b1;
        dividend = 4'd2;
        divisor  = 4'd9;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("d15_1_hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("d15_1_hold_quotient", 32'(quotient), 32'd15);
        end
        // Release happens while in_valid is high. The request must not be
        // taken on the same edge.
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("d15_1_released", 32'(out_valid), 32'd0);
        checkOutput("d2_9_not_taken", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("d2_9_taken", 32'(in_ready), 32'd0);
        waitResult(W, "d2_9", 1'b0);
        checkResult(2, 9, "d2_9");
        acceptResult(2, 9, "d2_9");

        // 7/0: divide by zero, one-cycle latency
        applyStimulus(7, 0, "d7_0");
        waitResult(1, "d7_0", 1'b0);
        checkResult(7, 0, "d7_0");
        acceptResult(7, 0, "d7_0");

        // 9/4 with out_ready held low. Stray in_valid pulses are ignored.
        applyStimulus(9, 4, "d9_4");
        waitResult(W, "d9_4", 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            dividend = 4'd3;
            divisor  = 4'd1;
            @(negedge clk);
            checkResult(9, 4, "d9_4_stall");
        end
        in_valid = 1'b0;
        acceptResult(9, 4, "d9_4");

        // Reset asserted during CALC step 2 of 14/5
        applyStimulus(14, 5, "d14_5_abort");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_quotient", 32'(quotient), 32'd0);
        checkOutput("abort_remainder", 32'(remainder), 32'd0);
        checkOutput("abort_zero", 32'(zero), 32'd0);
        checkOutput("abort_div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(14, 5, "d14_5");
        waitResult(W, "d14_5", 1'b0);
        checkResult(14, 5, "d14_5");
        acceptResult(14, 5, "d14_5");

        // Sweep over all operand pairs with randomized out_ready
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                int stall;
                applyStimulus(a, b, "sweep");
                waitResult((b == 0) ? 1 : W, "sweep", 1'b1);
                checkResult(a, b, "sweep");
                if (b != 0) begin
                    checkOutput("sweep_identity",
                                32'(int'(quotient) * b + int'(remainder)), 32'(a));
                    checkOutput("sweep_rem_lt_div", 32'(int'(remainder) < b), 32'd1);
                end
                stall = $urandom_range(0, 3);
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    checkOutput("sweep_stall_valid", 32'(out_valid), 32'd1);
                end
                acceptResult(a, b, "sweep");
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
